// File: rtl/trackball_pkg.sv
// Shared definitions for the trackball quadrature link.
// The mouse-side encoder uses the same bit positions.
package trackball_pkg;

   localparam int unsigned QUAD_W     = 4;
   localparam int unsigned QUAD_X_DIR = 3;
   localparam int unsigned QUAD_X_TOG = 2;
   localparam int unsigned QUAD_Y_DIR = 1;
   localparam int unsigned QUAD_Y_TOG = 0;

   localparam int unsigned DEF_SYNC_STAGES   = 2;
   localparam int unsigned DEF_FILTER_CYCLES = 4;
   localparam int unsigned DEF_CNT_W         = 4;

endpackage

// File: rtl/trackball_quad_decoder_if.sv
// CPU/trackball-side bundle of the quadrature decoder.
// The master drives the quadrature lines and read strobes; the slave is the decoder.
interface trackball_quad_decoder_if
   import trackball_pkg::*;
#(
   parameter int unsigned CNT_W = DEF_CNT_W
) ();

   logic              clr;
   logic [QUAD_W-1:0] quad_i;
   logic              rd_x;
   logic              rd_y;
   logic [CNT_W-1:0]  pos_x_o;
   logic              dir_x_o;
   logic [CNT_W-1:0]  pos_y_o;
   logic              dir_y_o;
   logic              moved_x_o;
   logic              moved_y_o;
   logic              step_x_o;
   logic              step_y_o;

   modport master (
      output clr, quad_i, rd_x, rd_y,
      input  pos_x_o, dir_x_o, pos_y_o, dir_y_o,
             moved_x_o, moved_y_o, step_x_o, step_y_o
   );

   modport slave (
      input  clr, quad_i, rd_x, rd_y,
      output pos_x_o, dir_x_o, pos_y_o, dir_y_o,
             moved_x_o, moved_y_o, step_x_o, step_y_o
   );

endinterface

// File: rtl/quad_axis.sv
// One trackball axis: synchronise and debounce a (dir, tog) pair, count steps,
// and latch the count/direction on a CPU read strobe.
module quad_axis #(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned FILTER_CYCLES = 4,
   parameter int unsigned CNT_W         = 4
) (
   input  logic             clk_sys,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             dir_i,
   input  logic             tog_i,
   input  logic             rd,
   output logic [CNT_W-1:0] pos_o,
   output logic             dir_o,
   output logic             moved_o,
   output logic             step_o
);

   localparam int unsigned FC_W = $clog2(FILTER_CYCLES) + 1;
   localparam int unsigned DIR  = 1;
   localparam int unsigned TOG  = 0;

   logic [1:0]                  raw_c;
   logic [1:0][SYNC_STAGES-1:0] sync_q;
   logic [1:0]                  sync_c;
   logic [1:0]                  filt_q, filt_d;
   logic [1:0][FC_W-1:0]        fcnt_q, fcnt_d;

   logic             tog_q, tog_d;
   logic             primed_q, primed_d;
   logic             tog_chg_c, step_c;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] pos_d;
   logic             dir_d, moved_d, step_d;

   assign raw_c = {dir_i, tog_i};

   // Synchroniser; clr intentionally leaves its contents alone.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
      end else begin
         for (int b = 0; b < 2; b++) begin
            sync_q[b] <= {sync_q[b][SYNC_STAGES-2:0], raw_c[b]};
         end
      end
   end

   always_comb begin
      for (int b = 0; b < 2; b++) begin
         sync_c[b] = sync_q[b][SYNC_STAGES-1];
      end
   end

   // Debounce: accept a level after FILTER_CYCLES consecutive differing samples.
   always_comb begin
      filt_d = filt_q;
      fcnt_d = '0;
      for (int b = 0; b < 2; b++) begin
         if (sync_c[b] != filt_q[b]) begin
            if (fcnt_q[b] == FC_W'(FILTER_CYCLES - 1)) begin
               filt_d[b] = sync_c[b];
            end else begin
               fcnt_d[b] = fcnt_q[b] + FC_W'(1);
            end
         end
      end
      if (clr) begin
         filt_d = '0;
         fcnt_d = '0;
      end
   end

   // The first filtered toggle change after reset/clr only establishes the baseline.
   assign tog_chg_c = filt_q[TOG] ^ tog_q;
   assign step_c    = tog_chg_c & primed_q;

   always_comb begin
      tog_d    = filt_q[TOG];
      primed_d = primed_q | tog_chg_c;
      cnt_d    = cnt_q;
      pos_d    = pos_o;
      dir_d    = dir_o;
      moved_d  = moved_o;
      step_d   = step_c;
      if (step_c) begin
         cnt_d = filt_q[DIR] ? cnt_q + CNT_W'(1) : cnt_q - CNT_W'(1);
      end
      if (rd) begin
         pos_d   = cnt_q;
         dir_d   = filt_q[DIR];
         moved_d = 1'b0;
      end
      if (step_c) begin
         moved_d = 1'b1;
      end
      if (clr) begin
         tog_d    = 1'b0;
         primed_d = 1'b0;
         cnt_d    = '0;
         pos_d    = '0;
         dir_d    = 1'b0;
         moved_d  = 1'b0;
         step_d   = 1'b0;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         filt_q   <= '0;
         fcnt_q   <= '0;
         tog_q    <= 1'b0;
         primed_q <= 1'b0;
         cnt_q    <= '0;
         pos_o    <= '0;
         dir_o    <= 1'b0;
         moved_o  <= 1'b0;
         step_o   <= 1'b0;
      end else begin
         filt_q   <= filt_d;
         fcnt_q   <= fcnt_d;
         tog_q    <= tog_d;
         primed_q <= primed_d;
         cnt_q    <= cnt_d;
         pos_o    <= pos_d;
         dir_o    <= dir_d;
         moved_o  <= moved_d;
         step_o   <= step_d;
      end
   end

endmodule

// File: rtl/trackball_quad_decoder.sv
// Game-side trackball quadrature receiver: splits the 4-bit stream into
// two independent quad_axis instances.
module trackball_quad_decoder
   import trackball_pkg::*;
#(
   parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int unsigned FILTER_CYCLES = DEF_FILTER_CYCLES,
   parameter int unsigned CNT_W         = DEF_CNT_W
) (
   input logic                     clk_sys,
   input logic                     reset_n,
   trackball_quad_decoder_if.slave bus
);

   quad_axis #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES),
      .CNT_W         (CNT_W)
   ) u_axis_x (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .clr     (bus.clr),
      .dir_i   (bus.quad_i[QUAD_X_DIR]),
      .tog_i   (bus.quad_i[QUAD_X_TOG]),
      .rd      (bus.rd_x),
      .pos_o   (bus.pos_x_o),
      .dir_o   (bus.dir_x_o),
      .moved_o (bus.moved_x_o),
      .step_o  (bus.step_x_o)
   );

   quad_axis #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES),
      .CNT_W         (CNT_W)
   ) u_axis_y (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .clr     (bus.clr),
      .dir_i   (bus.quad_i[QUAD_Y_DIR]),
      .tog_i   (bus.quad_i[QUAD_Y_TOG]),
      .rd      (bus.rd_y),
      .pos_o   (bus.pos_y_o),
      .dir_o   (bus.dir_y_o),
      .moved_o (bus.moved_y_o),
      .step_o  (bus.step_y_o)
   );

endmodule
